debug_log: RTL and testbench

- Per-tile trace buffer. Captures one WIDTH-bit debug record per cycle when `wvalid` is high.
- Stores records in a 2^LOG_DEPTH-entry FIFO backed by block RAM.
- Host software drains the records oldest-first over the PCI debug read channel.
- Current occupancy is exported on `size` so a register-bus readback can report it.

---
 rtl/debug_log.sv | 115 +++++++++++
 tb/tb_debug_log.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/debug_log.sv
// debug_log: per-tile trace buffer.
// Incoming debug records go into a block-RAM FIFO. The host drains them
// oldest-first over a single-outstanding PCI-style read channel. The read
// address is ignored: every accepted read pops the head of the FIFO.
module debug_log #(
    parameter int WIDTH     = 64,
    parameter int LOG_DEPTH = 10
) (
    input  logic                 clk,
    input  logic                 rstn,        // active-high synchronous reset despite the name
    input  logic                 wvalid,
    input  logic [WIDTH-1:0]     wdata,
    input  logic                 pci_arvalid,
    output logic                 pci_arready,
    input  logic [31:0]          pci_araddr,
    output logic                 pci_rvalid,
    input  logic                 pci_rready,
    output logic [511:0]         pci_rdata,
    output logic [LOG_DEPTH:0]   size
);

    localparam int                 DEPTH    = 1 << LOG_DEPTH;
    localparam logic [LOG_DEPTH:0] FULL_CNT = (LOG_DEPTH + 1)'(DEPTH);

    // Storage and FIFO bookkeeping
    logic [WIDTH-1:0]     r_mem [DEPTH];
    logic [LOG_DEPTH-1:0] r_wr_ptr;
    logic [LOG_DEPTH-1:0] r_rd_ptr;
    logic [LOG_DEPTH:0]   r_count;

    // Read response stage (one cycle behind the AR handshake)
    logic                 r_rvalid_p1;
    logic [WIDTH-1:0]     r_rdata_p1;

    logic                 w_full;
    logic                 w_empty;
    logic                 w_push;
    logic                 w_ar_hs;
    logic                 w_pop;
    logic                 w_unused;

    // The request address carries no information for a FIFO drain.
    assign w_unused = ^pci_araddr;

    // Full check always uses the count as it stands before this cycle's update,
    // so a write arriving while full is dropped even if a pop frees a slot.
    assign w_full  = (r_count == FULL_CNT);
    assign w_empty = (r_count == '0);
    assign w_push  = wvalid && !w_full;

    // Only one read may be outstanding; a new request is accepted as soon
    // as the previous response has been consumed and rvalid has dropped.
    assign pci_arready = !r_rvalid_p1;
    assign w_ar_hs     = pci_arvalid && pci_arready;
    assign w_pop       = w_ar_hs && !w_empty;

    // Record capture into the RAM; contents survive reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= wdata;
        end
    end

    // ---- stage p0 -> p1: registered RAM read on the AR handshake ----
    // An empty FIFO answers with zero data instead of a stale RAM word.
    // Reads never collide with a same-cycle write: a non-empty read address
    // differs from the write address unless full, and full blocks the write.
    always_ff @(posedge clk) begin
        if (w_ar_hs) begin
            r_rdata_p1 <= w_empty ? '0 : r_mem[r_rd_ptr];
        end
    end

    // Pointer, occupancy and response-valid control.
    always_ff @(posedge clk) begin
        if (rstn) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_rvalid_p1 <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            // Response holds until the host accepts it; an in-flight read
            // abandoned by reset simply never raises rvalid.
            if (w_ar_hs) begin
                r_rvalid_p1 <= 1'b1;
            end else if (pci_rready) begin
                r_rvalid_p1 <= 1'b0;
            end
        end
    end

    assign pci_rvalid = r_rvalid_p1;
    assign size       = r_count;

    // Zero-extend the record onto the fixed 512-bit read bus.
    generate
        if (WIDTH < 512) begin : g_pad
            assign pci_rdata = {{(512 - WIDTH){1'b0}}, r_rdata_p1};
        end else begin : g_nopad
            assign pci_rdata = r_rdata_p1;
        end
    endgenerate

endmodule

// File: tb/tb_debug_log.sv
// tb_debug_log: directed and randomized stimulus for debug_log, checked
// every cycle against a queue-based reference model of the trace FIFO.
module tb_debug_log;

    localparam int WIDTH     = 16;
    localparam int LOG_DEPTH = 2;
    localparam int DEPTH     = 1 << LOG_DEPTH;

    logic                 clk;
    logic                 rstn;
    logic                 wvalid;
    logic [WIDTH-1:0]     wdata;
    logic                 pci_arvalid;
    logic                 pci_arready;
    logic [31:0]          pci_araddr;
    logic                 pci_rvalid;
    logic                 pci_rready;
    logic [511:0]         pci_rdata;
    logic [LOG_DEPTH:0]   size;

    debug_log #(.WIDTH(WIDTH), .LOG_DEPTH(LOG_DEPTH)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .wvalid      (wvalid),
        .wdata       (wdata),
        .pci_arvalid (pci_arvalid),
        .pci_arready (pci_arready),
        .pci_araddr  (pci_araddr),
        .pci_rvalid  (pci_rvalid),
        .pci_rready  (pci_rready),
        .pci_rdata   (pci_rdata),
        .size        (size)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: stored records, plus the pending response.
    logic [WIDTH-1:0] m_q [$];
    logic             m_rvalid;
    logic [WIDTH-1:0] m_rdata;

    int n_checks = 0;
    int n_err    = 0;

    task automatic check_eq(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: compare outputs, drive inputs, advance the model.
    task automatic cyc(input logic wv, input logic [WIDTH-1:0] wd, input logic arv, input logic rr);
        logic             hs;
        logic             full;
        logic [WIDTH-1:0] d;
        @(negedge clk);
        check_eq("size", 512'(size), 512'(m_q.size()));
        check_eq("rvalid", 512'(pci_rvalid), 512'(m_rvalid));
        check_eq("arready", 512'(pci_arready), 512'(!m_rvalid));
        if (m_rvalid) begin
            check_eq("rdata", pci_rdata, {{(512 - WIDTH){1'b0}}, m_rdata});
        end
        wvalid      = wv;
        wdata       = wd;
        pci_arvalid = arv;
        pci_rready  = rr;
        pci_araddr  = $urandom;
        hs   = arv && !m_rvalid;
        full = (m_q.size() == DEPTH);
        if (hs) begin
            d = '0;
            if (m_q.size() > 0) d = m_q.pop_front();
            m_rvalid = 1'b1;
            m_rdata  = d;
        end else if (m_rvalid && rr) begin
            m_rvalid = 1'b0;
        end
        if (wv && !full) m_q.push_back(wd);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstn        = 1'b1;
        wvalid      = 1'b0;
        pci_arvalid = 1'b0;
        pci_rready  = 1'b0;
        @(negedge clk);
        rstn     = 1'b0;
        m_q.delete();
        m_rvalid = 1'b0;
    endtask

    task automatic read_one();
        cyc(1'b0, '0, 1'b1, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b1);
    endtask

    initial begin
        rstn        = 1'b1;
        wvalid      = 1'b0;
        wdata       = '0;
        pci_arvalid = 1'b0;
        pci_araddr  = '0;
        pci_rready  = 1'b0;
        m_rvalid    = 1'b0;
        do_reset();
        cyc(1'b0, '0, 1'b0, 1'b0);

        // Three writes, three reads
        cyc(1'b1, 16'h0011, 1'b0, 1'b0);
        cyc(1'b1, 16'h0022, 1'b0, 1'b0);
        cyc(1'b1, 16'h0033, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) read_one();
        cyc(1'b0, '0, 1'b0, 1'b0);

        // Overflow: 6 writes into depth 4
        for (int i = 1; i <= 6; i++) cyc(1'b1, WIDTH'(i), 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) read_one();

        // Read on empty
        read_one();
        cyc(1'b0, '0, 1'b0, 1'b0);

        // Backpressure: response held 5 cycles, arvalid kept high, writes allowed
        cyc(1'b1, 16'h00A1, 1'b0, 1'b0);
        cyc(1'b1, 16'h00A2, 1'b0, 1'b0);
        cyc(1'b0, '0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) cyc(i == 2, 16'h0077, 1'b1, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b1);
        cyc(1'b0, '0, 1'b0, 1'b0);

        // size == 2 here; write and pop in the same cycle
        cyc(1'b1, 16'h00AB, 1'b1, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) read_one();

        // Offset pointers, then fill/drain 3 entries ten times across the wrap
        cyc(1'b1, 16'h0F00, 1'b0, 1'b0);
        read_one();
        for (int k = 0; k < 10; k++) begin
            for (int i = 0; i < 3; i++) cyc(1'b1, WIDTH'(k * 16 + i + 16'h0100), 1'b0, 1'b0);
            for (int i = 0; i < 3; i++) read_one();
        end

        // Read in flight abandoned by reset
        cyc(1'b1, 16'h0BAD, 1'b0, 1'b0);
        cyc(1'b0, '0, 1'b1, 1'b0);
        do_reset();
        cyc(1'b0, '0, 1'b0, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b0);

        // Randomized traffic with one mid-run reset
        for (int n = 0; n < 3000; n++) begin
            if (n == 1500) do_reset();
            cyc(($urandom_range(0, 99) < 55), WIDTH'($urandom),
                ($urandom_range(0, 99) < 45), ($urandom_range(0, 99) < 60));
        end
        cyc(1'b0, '0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
